// File: rtl/ym3438_reg_pkg.sv
// Shared constants, FSM state type and helpers for the YM3438 register write path.
// Holds the global-register address map and the channel/operator -> slot mapping.
package ym3438_reg_pkg;

  localparam int SLOT_W = 5;

  localparam logic [7:0] REG_TEST   = 8'h21;
  localparam logic [7:0] REG_TA_H   = 8'h24;
  localparam logic [7:0] REG_TA_L   = 8'h25;
  localparam logic [7:0] REG_TB     = 8'h26;
  localparam logic [7:0] REG_MODE   = 8'h27;
  localparam logic [7:0] REG_KEYON  = 8'h28;
  localparam logic [7:0] REG_DAC    = 8'h2A;
  localparam logic [7:0] REG_DAC_EN = 8'h2B;
  localparam logic [7:0] REG_TEST2  = 8'h2C;
  localparam logic [7:0] OP_BASE    = 8'h30;
  localparam logic [7:0] CH_BASE    = 8'hA0;
  localparam logic [7:0] REG_LAST   = 8'hB6;

  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;

  // Bank 1 has no globals, so its valid window starts at the operator block.
  function automatic logic addr_ok(input logic [7:0] addr, input logic bnk);
    return (addr <= REG_LAST) && (bnk ? (addr >= OP_BASE) : (addr >= REG_TEST));
  endfunction

  function automatic logic [SLOT_W-1:0] calc_target(input logic [7:0] addr, input logic bnk);
    logic [1:0]        op;
    logic [SLOT_W-1:0] t;
    op = (addr < CH_BASE) ? addr[3:2] : 2'd0;
    t  = {3'b000, op} * 5'd6;
    t  = t + (bnk ? 5'd3 : 5'd0) + {3'b000, addr[1:0]};
    return t;
  endfunction

endpackage

// File: rtl/ym3438_slot_match.sv
// Free-running slot counter plus the pending-write slot compare and wait timer.
// match/timeout are combinational from registered state; only meaningful on a c1.
module ym3438_slot_match
  import ym3438_reg_pkg::*;
#(
  parameter int NUM_SLOTS  = 24,
  parameter int WAIT_LIMIT = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c1,
  input  logic [SLOT_W-1:0] target,
  input  logic              wait_clr,
  input  logic              wait_run,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic              match,
  output logic              timeout
);

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  logic [SLOT_W-1:0] slot_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  assign slot_nxt = (slot_cnt == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_cnt + SLOT_W'(1);

  // Compare against the slot being entered, so the commit cycle coincides with slot_cnt == target.
  assign match   = wait_run && (slot_nxt == target);
  assign timeout = wait_run && !match && (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      wait_cnt <= '0;
    end else if (c1) begin
      slot_cnt <= slot_nxt;
      if (wait_clr)
        wait_cnt <= '0;
      else if (wait_run)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/ym3438_reg_ctrl.sv
// Address latch, global registers 0x21-0x2C and slot-deferred channel/operator write commit.
// Optional YM3438_REG_READBACK_EN adds dbg_last = {bank, addr, data} of the last accepted data write.
module ym3438_reg_ctrl
  import ym3438_reg_pkg::*;
#(
  parameter int NUM_SLOTS  = 24,
  parameter int WAIT_LIMIT = 24
) (
  input  logic        MCLK,
  input  logic        IC,
  input  logic        c1,
  input  logic        c2,
  input  logic        write_addr_en,
  input  logic        write_data_en,
  input  logic [7:0]  data_bus,
  input  logic        bank,
  output logic [7:0]  reg_21,
  output logic [4:0]  reg_2c,
  output logic [9:0]  timer_a,
  output logic [7:0]  timer_b,
  output logic [7:0]  reg_27,
  output logic        keyon_pulse,
  output logic [7:0]  keyon_data,
  output logic [7:0]  dac_data,
  output logic        dac_en,
  output logic        slot_wr,
  output logic [7:0]  slot_addr,
  output logic [7:0]  slot_data,
  output logic [4:0]  slot_cnt,
  output logic        overrun
`ifdef YM3438_REG_READBACK_EN
  ,
  output logic [16:0] dbg_last
`endif
);

  logic              addr_req, data_req, addr_bank;
  logic [7:0]        addr_byte, data_byte;
  logic [7:0]        addr_q;
  logic              bank_q, addr_vld;
  state_t            state;
  logic [7:0]        pend_addr, pend_data;
  logic [SLOT_W-1:0] target_q;
  logic              wr_ok, glob_wr, chan_wr, match, timeout;

  // Decode uses the address latched before this c1, so a same-c1 address write lands afterwards.
  assign wr_ok   = c1 && data_req && addr_vld;
  assign glob_wr = wr_ok && !bank_q && (addr_q <= REG_TEST2);
  assign chan_wr = wr_ok && (addr_q >= OP_BASE) && (addr_q[1:0] != 2'd3);

  ym3438_slot_match #(
    .NUM_SLOTS  (NUM_SLOTS),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_slot_match (
    .clk      (MCLK),
    .rst_n    (IC),
    .c1       (c1),
    .target   (target_q),
    .wait_clr (chan_wr),
    .wait_run (state == PEND),
    .slot_cnt (slot_cnt),
    .match    (match),
    .timeout  (timeout)
  );

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      addr_req  <= 1'b0;
      data_req  <= 1'b0;
      addr_byte <= '0;
      addr_bank <= 1'b0;
      data_byte <= '0;
    end else begin
      if (c1) begin
        addr_req <= 1'b0;
        data_req <= 1'b0;
      end
      if (c2 && write_addr_en) begin
        addr_req  <= 1'b1;
        addr_byte <= data_bus;
        addr_bank <= bank;
      end
      if (c2 && write_data_en) begin
        data_req  <= 1'b1;
        data_byte <= data_bus;
      end
    end
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      addr_q      <= '0;
      bank_q      <= 1'b0;
      addr_vld    <= 1'b0;
      reg_21      <= '0;
      reg_2c      <= '0;
      timer_a     <= '0;
      timer_b     <= '0;
      reg_27      <= '0;
      keyon_pulse <= 1'b0;
      keyon_data  <= '0;
      dac_data    <= '0;
      dac_en      <= 1'b0;
    end else if (c1) begin
      keyon_pulse <= 1'b0;
      if (glob_wr) begin
        case (addr_q)
          REG_TEST:   reg_21        <= data_byte;
          REG_TA_H:   timer_a[9:2]  <= data_byte;
          REG_TA_L:   timer_a[1:0]  <= data_byte[1:0];
          REG_TB:     timer_b       <= data_byte;
          REG_MODE:   reg_27        <= data_byte;
          REG_KEYON: begin
            keyon_data  <= data_byte;
            keyon_pulse <= 1'b1;
          end
          REG_DAC:    dac_data      <= data_byte;
          REG_DAC_EN: dac_en        <= data_byte[7];
          REG_TEST2:  reg_2c        <= data_byte[7:3];
          default: ;
        endcase
      end
      if (addr_req) begin
        addr_q   <= addr_byte;
        bank_q   <= addr_bank;
        addr_vld <= addr_ok(addr_byte, addr_bank);
      end
    end
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      state     <= IDLE;
      pend_addr <= '0;
      pend_data <= '0;
      target_q  <= '0;
      slot_wr   <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
      overrun   <= 1'b0;
    end else if (c1) begin
      slot_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (chan_wr)
            state <= PEND;
        end
        PEND: begin
          if (chan_wr) begin
            overrun <= 1'b1;
          end else if (match) begin
            state     <= COMMIT;
            slot_wr   <= 1'b1;
            slot_addr <= pend_addr;
            slot_data <= pend_data;
          end else if (timeout) begin
            state   <= IDLE;
            overrun <= 1'b1;
          end
        end
        COMMIT:  state <= chan_wr ? PEND : IDLE;
        default: state <= IDLE;
      endcase
      if (chan_wr) begin
        pend_addr <= addr_q;
        pend_data <= data_byte;
        target_q  <= calc_target(addr_q, bank_q);
      end
    end
  end

`ifdef YM3438_REG_READBACK_EN
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC)
      dbg_last <= '0;
    else if (wr_ok)
      dbg_last <= {bank_q, addr_q, data_byte};
  end
`endif

endmodule
